// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
// State and owner types used by the arbiter and its bench.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_ACK    = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side bus bundle for the port arbiter.
// slave is the arbiter's view; master is the cpu/memory view.
interface mem_port_arbiter_if #(
    parameter int W = 16
);
    logic         i_req;
    logic         i_write;
    logic [W-1:0] i_addr;
    logic [W-1:0] i_wdata;
    logic         i_ack;
    logic [W-1:0] i_rdata;

    logic         d_req;
    logic         d_write;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic         d_ack;
    logic [W-1:0] d_rdata;

    logic         m_read;
    logic         m_write;
    logic [W-1:0] m_addr;
    logic [W-1:0] m_wdata;
    logic [W-1:0] m_rdata;

    logic         busy;

    modport slave (
        input  i_req, i_write, i_addr, i_wdata,
        input  d_req, d_write, d_addr, d_wdata,
        input  m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata,
        output m_read, m_write, m_addr, m_wdata,
        output busy
    );

    modport master (
        output i_req, i_write, i_addr, i_wdata,
        output d_req, d_write, d_addr, d_wdata,
        output m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  m_read, m_write, m_addr, m_wdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and data sides.
// Data wins ties; a fetch that has waited STARVE_LIMIT cycles wins.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int LATENCY      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic reset,
    mem_port_arbiter_if.slave bus
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

    arb_state_e           state_q, state_d;
    owner_e               owner_q, owner_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 write_q, write_d;
    logic                 m_read_q, m_read_d;
    logic                 m_write_q, m_write_d;
    logic                 i_ack_q, i_ack_d;
    logic                 d_ack_q, d_ack_d;
    logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
    logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
    logic                 grant_i, grant_d;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        i_ack_d   = i_ack_q;
        d_ack_d   = d_ack_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        grant_i   = 1'b0;
        grant_d   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                grant_i = bus.i_req && (!bus.d_req || wait_q >= WAIT_MAX);
                grant_d = bus.d_req && !grant_i;
                if (grant_i || grant_d) begin
                    state_d   = ARB_ACCESS;
                    cnt_d     = CNT_LOAD;
                    owner_d   = grant_i ? OWNER_I : OWNER_D;
                    addr_d    = grant_i ? bus.i_addr : bus.d_addr;
                    wdata_d   = grant_i ? bus.i_wdata : bus.d_wdata;
                    write_d   = grant_i ? bus.i_write : bus.d_write;
                    m_read_d  = !write_d;
                    m_write_d = write_d;
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d   = ARB_ACK;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    if (owner_q == OWNER_I) begin
                        i_ack_d = 1'b1;
                        if (!write_q) i_rdata_d = bus.m_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!write_q) d_rdata_d = bus.m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            // Owner's req is still high here, so no arbitration.
            ARB_ACK: begin
                state_d = ARB_IDLE;
                i_ack_d = 1'b0;
                d_ack_d = 1'b0;
            end
            default: state_d = ARB_IDLE;
        endcase

        wait_d = wait_q;
        if (grant_i || !bus.i_req) begin
            wait_d = '0;
        end else if (wait_q < WAIT_MAX) begin
            wait_d = wait_q + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_D;
            cnt_q     <= '0;
            wait_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.m_read  = m_read_q;
    assign bus.m_write = m_write_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table
// plus hand sequences for reset, starvation and aborted access.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_port_arbiter_if #(.W(16)) bus ();

    mem_port_arbiter #(
        .WORD_SIZE(16),
        .LATENCY(2),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir, iw;
        logic [15:0] ia, iwd;
        logic        dr, dw;
        logic [15:0] da, dwd, mrd;
        logic        e_mr, e_mw;
        logic [15:0] e_ma, e_mwd;
        logic        e_ia, e_da;
        logic [15:0] e_ird, e_drd;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic ir, input logic iw,
        input logic [15:0] ia, input logic [15:0] iwd,
        input logic dr, input logic dw,
        input logic [15:0] da, input logic [15:0] dwd,
        input logic [15:0] mrd,
        input logic e_mr, input logic e_mw,
        input logic [15:0] e_ma, input logic [15:0] e_mwd,
        input logic e_ia, input logic e_da,
        input logic [15:0] e_ird, input logic [15:0] e_drd,
        input logic e_busy);
        vec_t v;
        v.ir = ir; v.iw = iw; v.ia = ia; v.iwd = iwd;
        v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.mrd = mrd;
        v.e_mr = e_mr; v.e_mw = e_mw;
        v.e_ma = e_ma; v.e_mwd = e_mwd;
        v.e_ia = e_ia; v.e_da = e_da;
        v.e_ird = e_ird; v.e_drd = e_drd;
        v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " m_read"},  16'(bus.m_read),  16'(v.e_mr));
        check({tag, " m_write"}, 16'(bus.m_write), 16'(v.e_mw));
        check({tag, " m_addr"},  bus.m_addr,       v.e_ma);
        check({tag, " m_wdata"}, bus.m_wdata,      v.e_mwd);
        check({tag, " i_ack"},   16'(bus.i_ack),   16'(v.e_ia));
        check({tag, " d_ack"},   16'(bus.d_ack),   16'(v.e_da));
        check({tag, " i_rdata"}, bus.i_rdata,      v.e_ird);
        check({tag, " d_rdata"}, bus.d_rdata,      v.e_drd);
        check({tag, " busy"},    16'(bus.busy),    16'(v.e_busy));
    endtask

    task automatic drive(input vec_t v);
        bus.i_req   = v.ir;
        bus.i_write = v.iw;
        bus.i_addr  = v.ia;
        bus.i_wdata = v.iwd;
        bus.d_req   = v.dr;
        bus.d_write = v.dw;
        bus.d_addr  = v.da;
        bus.d_wdata = v.dwd;
        bus.m_rdata = v.mrd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t zero_v;
    logic [15:0] grants[4];
    int   ng, ndack, icyc;
    logic prev_mr, seen;

    initial begin
        total = 0;
        bad   = 0;
        zero_v = '{default: '0};

        // Reset held with a pending data request: everything stays 0.
        reset = 1'b1;
        drive(zero_v);
        bus.d_req   = 1'b1;
        bus.d_addr  = 16'h0002;
        bus.m_rdata = 16'h0001;
        tick();
        tick();
        check_all("reset", zero_v);

        reset = 1'b0;
        tick();
        check("rel m_read", 16'(bus.m_read), 16'h0001);
        check("rel m_addr", bus.m_addr, 16'h0002);
        check("rel busy", 16'(bus.busy), 16'h0001);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            tick();
            if (bus.d_ack) seen = 1'b1;
        end
        check("rel d_ack seen", 16'(seen), 16'h0001);
        check("rel d_rdata", bus.d_rdata, 16'h0001);
        bus.d_req = 1'b0;
        tick();
        tick();

        // ir iw ia iwd dr dw da dwd mrd | mr mw ma mwd ia da ird drd busy
        add(1,0,16'h0010,0, 0,0,0,0, 16'hBEEF,
            1,0,16'h0010,0, 0,0,16'h0000,16'h0001,1);
        add(1,0,16'h0010,0, 0,0,0,0, 16'hBEEF,
            1,0,16'h0010,0, 0,0,16'h0000,16'h0001,1);
        add(1,0,16'h0010,0, 0,0,0,0, 16'hBEEF,
            0,0,16'h0010,0, 1,0,16'hBEEF,16'h0001,1);
        add(1,0,16'h0010,0, 0,0,0,0, 16'hBEEF,
            0,0,16'h0010,0, 0,0,16'hBEEF,16'h0001,0);
        add(0,0,0,0, 0,0,0,0, 16'hBEEF,
            0,0,16'h0010,0, 0,0,16'hBEEF,16'h0001,0);
        add(0,0,0,0, 1,1,16'h0020,16'h1234, 16'hDEAD,
            0,1,16'h0020,16'h1234, 0,0,16'hBEEF,16'h0001,1);
        add(0,0,0,0, 1,0,16'h0099,16'hFFFF, 16'hDEAD,
            0,1,16'h0020,16'h1234, 0,0,16'hBEEF,16'h0001,1);
        add(0,0,0,0, 1,1,16'h0020,16'h1234, 16'hDEAD,
            0,0,16'h0020,16'h1234, 0,1,16'hBEEF,16'h0001,1);
        add(0,0,0,0, 0,0,0,0, 16'hDEAD,
            0,0,16'h0020,16'h1234, 0,0,16'hBEEF,16'h0001,0);
        add(1,0,16'h0040,0, 1,0,16'h0030,0, 16'h5555,
            1,0,16'h0030,0, 0,0,16'hBEEF,16'h0001,1);
        add(1,0,16'h0040,0, 1,0,16'h0030,0, 16'h5555,
            1,0,16'h0030,0, 0,0,16'hBEEF,16'h0001,1);
        add(1,0,16'h0040,0, 1,0,16'h0030,0, 16'h5555,
            0,0,16'h0030,0, 0,1,16'hBEEF,16'h5555,1);
        add(1,0,16'h0040,0, 0,0,0,0, 16'h6666,
            0,0,16'h0030,0, 0,0,16'hBEEF,16'h5555,0);
        add(1,0,16'h0040,0, 0,0,0,0, 16'h6666,
            1,0,16'h0040,0, 0,0,16'hBEEF,16'h5555,1);
        add(1,0,16'h0040,0, 0,0,0,0, 16'h6666,
            1,0,16'h0040,0, 0,0,16'hBEEF,16'h5555,1);
        add(1,0,16'h0040,0, 0,0,0,0, 16'h6666,
            0,0,16'h0040,0, 1,0,16'h6666,16'h5555,1);
        add(0,0,0,0, 0,0,0,0, 16'h0000,
            0,0,16'h0040,0, 0,0,16'h6666,16'h5555,0);

        foreach (vecs[n]) begin
            drive(vecs[n]);
            tick();
            check_all($sformatf("vec%0d", n), vecs[n]);
        end

        // Data requests back-to-back, fetch held: second grant is fetch.
        bus.m_rdata = 16'h7777;
        bus.i_req   = 1'b1;
        bus.i_addr  = 16'h0060;
        bus.d_req   = 1'b1;
        bus.d_addr  = 16'h0050;
        ng = 0; ndack = 0; icyc = 0; prev_mr = 1'b0;
        for (int c = 1; c <= 12 && icyc == 0; c++) begin
            tick();
            if (bus.m_read && !prev_mr && ng < 4) begin
                grants[ng] = bus.m_addr;
                ng++;
            end
            prev_mr = bus.m_read;
            if (bus.d_ack) ndack++;
            if (bus.i_ack) icyc = c;
        end
        check("starve i_ack seen", 16'(icyc != 0), 16'h0001);
        check("starve i_ack by 9", 16'(icyc <= 9), 16'h0001);
        check("starve ngrants", 16'(ng), 16'h0002);
        check("starve grant0", grants[0], 16'h0050);
        check("starve grant1", grants[1], 16'h0060);
        check("starve d_acks", 16'(ndack), 16'h0001);
        check("starve i_rdata", bus.i_rdata, 16'h7777);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        tick();
        tick();

        // Reset during the first strobe cycle of a data read.
        bus.m_rdata = 16'hAAAA;
        bus.d_req   = 1'b1;
        bus.d_addr  = 16'h0070;
        tick();
        check("abort m_read pre", 16'(bus.m_read), 16'h0001);
        check("abort m_addr pre", bus.m_addr, 16'h0070);
        #2;
        reset = 1'b1;
        #1;
        check_all("abort", zero_v);
        bus.d_req = 1'b0;
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.d_ack || bus.busy) seen = 1'b1;
        end
        check("abort no ack", 16'(seen), 16'h0000);
        check("abort d_rdata", bus.d_rdata, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
